// File: rtl/lcd_text_scanner.sv
// -----------------------------------------------------------------------------
// lcd_text_scanner
//
// Text-mode front end of the LCD pixel pipeline. Converts raw pixel
// coordinates into a character cell request (column, row), fetches the
// returned character's glyph line from an external synchronous font ROM and
// emits one RGB pixel per input pixel with a fixed 4-clock latency.
//
// Pipeline:
//   S0  register cell request, pixel offset, glyph line, range and valid
//   S1  register font ROM address {character, glyph_line}
//   S2  wait for the ROM (font_data valid after this edge)
//   S3  select foreground/background colour
//
// Ports:
//   clock            pixel clock, all logic on rising edge
//   reset            synchronous, active-high reset
//   pixel_x/pixel_y  10-bit pixel coordinates from the timing generator
//   pixel_valid      coordinates are in the active display area
//   frame_start      one-cycle pulse per frame (drives the cursor blink only)
//   column/row       registered character cell request
//   character        character code for (column, row), combinational reply
//   font_address     {character, glyph_line[3:0]} to the font ROM
//   font_data        glyph line, bit 7 = leftmost pixel, one cycle after addr
//   pixel_rgb        rendered pixel
//   pixel_out_valid  pixel_valid delayed by 4 clocks
//
// Optional build macro LCD_TEXT_SCANNER_CURSOR_EN adds cursor_column,
// cursor_row and cursor_enable inputs plus a 5-bit frame counter; the cursor
// cell's glyph bits are inverted during the "on" half of each 32-frame blink.
// -----------------------------------------------------------------------------
module lcd_text_scanner #(
  parameter int unsigned COLUMNS  = 100,
  parameter int unsigned ROWS     = 30,
  parameter logic [23:0] FG_COLOR = 24'hFFFFFF,
  parameter logic [23:0] BG_COLOR = 24'h000000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [9:0]  pixel_x,
  input  logic [9:0]  pixel_y,
  input  logic        pixel_valid,
  input  logic        frame_start,
  output logic [6:0]  column,
  output logic [5:0]  row,
  input  logic [6:0]  character,
  output logic [10:0] font_address,
  input  logic [7:0]  font_data,
  output logic [23:0] pixel_rgb,
  output logic        pixel_out_valid
`ifdef LCD_TEXT_SCANNER_CURSOR_EN
  ,
  input  logic [6:0]  cursor_column,
  input  logic [5:0]  cursor_row,
  input  logic        cursor_enable
`endif
);

  localparam int unsigned X_LIMIT = COLUMNS * 8;
  localparam int unsigned Y_LIMIT = ROWS * 16;

  // Sideband that travels with each pixel through the pipeline.
  typedef struct packed {
    logic [2:0] x;      // pixel offset inside the glyph line
    logic       range;  // pixel lies inside the text area
    logic       valid;  // active display pixel
    logic       match;  // pixel belongs to the cursor cell
  } side_t;

  side_t       s0_d, s0_q, s1_q, s2_q;
  logic [6:0]  column_q;
  logic [5:0]  row_q;
  logic [3:0]  s0_line_q;
  logic [10:0] font_address_q;
  logic [23:0] pixel_rgb_d, pixel_rgb_q;
  logic        pixel_out_valid_q;
  logic        blink;
  logic        glyph_bit;
  logic        lit;

  // NOTE: every variable gets a default at the top of an always_comb block so
  // no path leaves it unassigned, which is what would otherwise infer a latch.
  always_comb begin
    s0_d       = '0;
    s0_d.x     = pixel_x[2:0];
    // Compared at full width so coordinates past the text area never alias
    // back into it through the truncated column/row.
    s0_d.range = (32'(pixel_x) < X_LIMIT) && (32'(pixel_y) < Y_LIMIT);
    s0_d.valid = pixel_valid;
`ifdef LCD_TEXT_SCANNER_CURSOR_EN
    s0_d.match = cursor_enable && (pixel_x[9:3] == cursor_column) &&
                 (pixel_y[9:4] == cursor_row);
`endif
  end

`ifdef LCD_TEXT_SCANNER_CURSOR_EN
  logic [4:0] frame_cnt_q;

  // Free-running frame counter; the MSB gives 16 frames on, 16 frames off.
  always_ff @(posedge clock) begin
    if (reset) begin
      frame_cnt_q <= '0;
    end else if (frame_start) begin
      frame_cnt_q <= frame_cnt_q + 5'd1;
    end
  end

  assign blink = frame_cnt_q[4];
`else
  // frame_start only feeds the cursor blink, absent in this build.
  logic unused_frame_start;
  assign unused_frame_start = frame_start;
  assign blink = 1'b0;
`endif

  // font_data arrives aligned with the S2 sideband.
  assign glyph_bit   = font_data[3'd7 - s2_q.x];
  assign lit         = s2_q.range && (glyph_bit ^ (s2_q.match && blink));
  assign pixel_rgb_d = lit ? FG_COLOR : BG_COLOR;

  // NOTE: sequential state uses non-blocking assignments so every stage
  // samples the previous stage's value from before the edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      // The whole pipeline is flushed at once so no stale pixel escapes.
      column_q          <= '0;
      row_q             <= '0;
      s0_line_q         <= '0;
      s0_q              <= '0;
      s1_q              <= '0;
      s2_q              <= '0;
      font_address_q    <= '0;
      pixel_rgb_q       <= '0;
      pixel_out_valid_q <= 1'b0;
    end else begin
      // S0: cell request (upper bits truncate to the port width)
      column_q          <= pixel_x[9:3];
      row_q             <= pixel_y[9:4];
      s0_line_q         <= pixel_y[3:0];
      s0_q              <= s0_d;
      // S1: the character source has answered for column/row
      font_address_q    <= {character, s0_line_q};
      s1_q              <= s0_q;
      // S2: ROM access in flight
      s2_q              <= s1_q;
      // S3: colour selection
      pixel_rgb_q       <= pixel_rgb_d;
      pixel_out_valid_q <= s2_q.valid;
    end
  end

  assign column          = column_q;
  assign row             = row_q;
  assign font_address    = font_address_q;
  assign pixel_rgb       = pixel_rgb_q;
  assign pixel_out_valid = pixel_out_valid_q;

endmodule

// File: tb/tb_lcd_text_scanner.sv
// -----------------------------------------------------------------------------
// tb_lcd_text_scanner
//
// Self-checking bench for lcd_text_scanner. A character source and a
// synchronous font ROM are modelled here; every input pixel is turned into an
// expected result from the rendering rules (cell = coordinate / glyph size,
// glyph bit = ROM[char*16 + line] >> (7 - x%8)) and held in a queue until the
// pixel is due at the output. Build with +define+LCD_TEXT_SCANNER_CURSOR_EN
// to exercise the cursor as well.
// -----------------------------------------------------------------------------
module tb_lcd_text_scanner;

  localparam int unsigned COLUMNS  = 100;
  localparam int unsigned ROWS     = 30;
  localparam logic [23:0] FG_COLOR = 24'hFFFFFF;
  localparam logic [23:0] BG_COLOR = 24'h000000;

  logic        clock = 1'b0;
  logic        reset;
  logic [9:0]  pixel_x;
  logic [9:0]  pixel_y;
  logic        pixel_valid;
  logic        frame_start;
  logic [6:0]  column;
  logic [5:0]  row;
  logic [6:0]  character;
  logic [10:0] font_address;
  logic [7:0]  font_data;
  logic [23:0] pixel_rgb;
  logic        pixel_out_valid;
`ifdef LCD_TEXT_SCANNER_CURSOR_EN
  logic [6:0]  cursor_column;
  logic [5:0]  cursor_row;
  logic        cursor_enable;
`endif

  lcd_text_scanner #(
    .COLUMNS (COLUMNS),
    .ROWS    (ROWS),
    .FG_COLOR(FG_COLOR),
    .BG_COLOR(BG_COLOR)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .pixel_x        (pixel_x),
    .pixel_y        (pixel_y),
    .pixel_valid    (pixel_valid),
    .frame_start    (frame_start),
    .column         (column),
    .row            (row),
    .character      (character),
    .font_address   (font_address),
    .font_data      (font_data),
    .pixel_rgb      (pixel_rgb),
    .pixel_out_valid(pixel_out_valid)
`ifdef LCD_TEXT_SCANNER_CURSOR_EN
    ,
    .cursor_column  (cursor_column),
    .cursor_row     (cursor_row),
    .cursor_enable  (cursor_enable)
`endif
  );

  always #5 clock = ~clock;

  // ---------------------------------------------------------------------------
  // Character source and font ROM models
  // ---------------------------------------------------------------------------
  logic       char_const;   // 1: every cell holds 7'h41
  logic [7:0] rom [0:2047];

  function automatic logic [6:0] char_fn(int c, int r);
    if (char_const) return 7'h41;
    return 7'((c * 5 + r * 3 + 17) % 128);
  endfunction

  assign character = char_fn(int'(column), int'(row));

  always @(posedge clock) font_data <= rom[font_address];

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic valid;
    logic range;
    logic glyph;
    logic match;
  } exp_t;

  exp_t q[$];
  int   frames_m;
  int   n_checks;
  int   n_pass;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic exp_t model_pix(int x, int y, logic v);
    exp_t       e;
    logic [6:0] ch;
    logic [7:0] g;
    e       = '0;
    e.valid = v;
    e.range = (x < int'(COLUMNS) * 8) && (y < int'(ROWS) * 16);
    ch      = char_fn(x / 8, y / 16);
    g       = rom[int'(ch) * 16 + (y % 16)];
    e.glyph = g[7 - (x % 8)];
`ifdef LCD_TEXT_SCANNER_CURSOR_EN
    e.match = cursor_enable && (x / 8 == int'(cursor_column)) &&
              (y / 16 == int'(cursor_row));
`endif
    return e;
  endfunction

  // One clock: the DUT captures the current inputs at the edge, the model
  // records the expectation, and the output due at this edge is compared.
  task automatic cycle();
    exp_t e;
    exp_t o;
    logic blink_now;
    logic [23:0] rgb_exp;
    @(posedge clock);
    blink_now = (frames_m / 16) % 2 == 1;
    if (reset) begin
      q.delete();
      repeat (3) q.push_back('0);
      frames_m = 0;
      #1;
      check("reset_valid", 32'(pixel_out_valid), 32'd0);
      check("reset_rgb", 32'(pixel_rgb), 32'd0);
    end else begin
      if (frame_start) frames_m = (frames_m + 1) % 32;
      e = model_pix(int'(pixel_x), int'(pixel_y), pixel_valid);
      q.push_back(e);
      o = q.pop_front();
      rgb_exp = (o.range && (o.glyph ^ (o.match && blink_now))) ? FG_COLOR : BG_COLOR;
      #1;
      check("out_valid", 32'(pixel_out_valid), 32'(o.valid));
      if (o.valid) check("pixel_rgb", 32'(pixel_rgb), 32'(rgb_exp));
    end
  endtask

  task automatic drive(int x, int y, logic v);
    pixel_x     = 10'(x);
    pixel_y     = 10'(y);
    pixel_valid = v;
    cycle();
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) drive(int'($urandom_range(1023)), int'($urandom_range(1023)), 1'b0);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    n_checks    = 0;
    n_pass      = 0;
    frames_m    = 0;
    char_const  = 1'b0;
    reset       = 1'b1;
    pixel_x     = '0;
    pixel_y     = '0;
    pixel_valid = 1'b1;
    frame_start = 1'b0;
`ifdef LCD_TEXT_SCANNER_CURSOR_EN
    cursor_column = 7'd127;
    cursor_row    = 6'd63;
    cursor_enable = 1'b0;
`endif
    for (int i = 0; i < 2048; i++) rom[i] = 8'($urandom);

    // Reset held 3 cycles with valid pixels, then 3 bubble cycles.
    for (int i = 0; i < 3; i++) drive(i * 8, 0, 1'b1);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(i, 0, 1'b1);
      check("post_reset_rgb", 32'(pixel_rgb), 32'd0);
    end
    idle(4);

    // Glyph render: line 5 of 'A' = 8'h18 -> BG BG BG FG FG BG BG BG.
    char_const   = 1'b1;
    rom[11'h415] = 8'h18;
    drive(0, 5, 1'b1);
    drive(1, 5, 1'b1);
    check("font_address", 32'(font_address), 32'h415);
    for (int x = 2; x < 8; x++) drive(x, 5, 1'b1);
    idle(4);
    char_const = 1'b0;

    // Cell mapping at the right edge: column 100 is outside the text area.
    rom[int'(char_fn(100, 2)) * 16 + 5] = 8'hFF;
    drive(803, 37, 1'b1);
    check("column", 32'(column), 32'd100);
    check("row", 32'(row), 32'd2);
    idle(4);

    // Bubbles: valid pattern 1,0,1,1,0.
    drive(16, 20, 1'b1);
    drive(24, 20, 1'b0);
    drive(32, 20, 1'b1);
    drive(40, 20, 1'b1);
    drive(48, 20, 1'b0);
    idle(4);

    // Mid-frame reset with 4 valid pixels in flight.
    for (int i = 0; i < 4; i++) drive(64 + i, 40, 1'b1);
    reset = 1'b1;
    drive(72, 40, 1'b1);
    reset = 1'b0;
    idle(3);
    drive(80, 41, 1'b1);
    idle(5);

    // Randomized traffic, including occasional frame_start pulses.
    for (int i = 0; i < 600; i++) begin
      frame_start = ($urandom_range(7) == 0);
      drive(int'($urandom_range(1023)), int'($urandom_range(1023)), 1'($urandom));
    end
    frame_start = 1'b0;
    idle(4);

`ifdef LCD_TEXT_SCANNER_CURSOR_EN
    // Cursor at (1,0) over blank glyphs.
    for (int i = 0; i < 2048; i++) rom[i] = 8'h00;
    cursor_column = 7'd1;
    cursor_row    = 6'd0;
    cursor_enable = 1'b1;
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    for (int pass = 0; pass < 2; pass++) begin
      frame_start = 1'b1;
      idle(16);
      frame_start = 1'b0;
      for (int x = 8; x < 24; x++) drive(x, 0, 1'b1);
      idle(4);
    end
    for (int i = 0; i < 100; i++) begin
      frame_start = ($urandom_range(3) == 0);
      cursor_enable = 1'($urandom);
      drive(int'($urandom_range(31)), int'($urandom_range(31)), 1'b1);
    end
    frame_start = 1'b0;
    idle(4);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
